f1_start_ctrl: RTL and testbench
================================

Name: f1_start_ctrl

Overview:
- Race-start controller for the 8-light F1 light bar.
- On a trigger, lights the bar one lamp per tick, holds all 8 lamps for a pseudo-random number of ticks, then blanks the bar ("go").
- Measures the player's reaction time in clock cycles and flags false starts.
- Sits between the top-level push-button inputs and the 8-bit LED bar output.

Parameters:
- TICK_DIV, 16, clock cycles per light tick (>=2; set to the board clock rate for a 1 s tick on hardware)
- MIN_DELAY, 2, minimum hold ticks with all lamps lit (>=1)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- trigger  in  1  start request, level-sampled, honoured only in IDLE
- react  in  1  player button, level-sampled
- data_out  out  8  light bar, thermometer code
- busy  out  1  high in every state except IDLE
- react_valid  out  1  one-cycle pulse when react_time is updated
- react_time  out  16  last valid reaction time in cycles
- false_start  out  1  one-cycle pulse when react is seen during LIGHTS or HOLD

Behaviour:
- Reset, asynchronous on rst=0:
  - state=IDLE, data_out=0, busy=0, react_valid=0, false_start=0, react_time=0.
  - lamp count=0, tick counter=0, LFSR=8'h01.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, new bit0 = b7^b5^b4^b3.
  - Advances every cycle in every state; it is never all-zero.
- Tick generator:
  - tick_cnt runs only in LIGHTS/HOLD and is cleared to 0 on entry to LIGHTS and on every wrap.
  - tick is combinational: tick = (tick_cnt == TICK_DIV-1).
- States: IDLE, LIGHTS, HOLD, GO, DONE.
- IDLE:
  - data_out=0.
  - trigger=1 at an edge -> LIGHTS; lamp count=0, tick_cnt=0.
  - react ignored.
- LIGHTS:
  - On each tick, lamp count +1 and data_out=(1<<count)-1.
  - Lamp n appears exactly n*TICK_DIV cycles after the entry edge.
  - The tick that lights lamp 8 (data_out=8'hFF) -> HOLD, and loads delay D = MIN_DELAY + LFSR[3:0] using the current LFSR value at that edge.
- HOLD:
  - data_out=8'hFF; D decrements on each tick.
  - The tick on which D==1 -> GO, data_out=0, react counter=0.
  - Lamps go out (8+D)*TICK_DIV cycles after LIGHTS entry.
- GO:
  - data_out=0; react counter +1 per cycle, saturating at 16'hFFFF.
  - react=1 at an edge: react_time <= current counter value (pre-increment), react_valid=1 for that one following cycle, -> DONE.
  - react already high on GO entry is captured at the first GO edge, giving react_time=0.
- DONE: one cycle, then IDLE. react_valid deasserts here.
- False start: react=1 at an edge in LIGHTS or HOLD:
  - false_start pulses for one cycle, data_out=0, -> IDLE.
  - react_time is unchanged and react_valid stays 0.
  - If the same edge has a tick, react wins.
- Simultaneous events:
  - trigger is ignored outside IDLE.
  - trigger and react both high in IDLE -> LIGHTS; react is not checked until the next edge.
- busy=1 in LIGHTS, HOLD, GO and DONE.
- Reset mid-sequence: immediate return to reset values.
- Outputs are registered except busy, which is decoded from state.

Test Plan:
- Reset/idle: rst=0 then 1, no trigger for 100 cycles -> data_out=0, busy=0, no pulses; LFSR sequence matches bench model starting 8'h01.
- Full sequence with TICK_DIV=4, MIN_DELAY=2, trigger pulse at edge T, react asserted 10 cycles after lamps go out:
  - data_out = 01, 03, 07, 0F, 1F, 3F, 7F, FF at T+4, T+8, ..., T+32.
  - 00 at T+32+4*D, with D from the bench LFSR model.
  - react_time=9, react_valid single pulse, busy low 2 cycles after react.
- False start: react pulsed while data_out=8'h07 -> false_start one pulse, data_out=0 next cycle, state IDLE, react_time keeps its previous value.
- Held button: react held high from the moment lamps go out -> react_time=0.
- No-react saturation: no react in GO for 70000 cycles, then react -> react_time=16'hFFFF.
- Mid-sequence reset: rst low in HOLD -> outputs clear asynchronously before the next clk edge; re-trigger after release restarts from lamp 1 at +TICK_DIV.
- Trigger in GO is ignored.

Source files
------------

// File: rtl/f1_start_ctrl_if.sv
// Handshake and light-bar signals between the push-button top level and f1_start_ctrl.
// master drives the buttons, slave (the controller) drives the bar and reaction results.
interface f1_start_ctrl_if;
    logic        trigger;
    logic        react;
    logic [7:0]  data_out;
    logic        busy;
    logic        react_valid;
    logic [15:0] react_time;
    logic        false_start;

    modport master (
        output trigger, react,
        input  data_out, busy, react_valid, react_time, false_start
    );

    modport slave (
        input  trigger, react,
        output data_out, busy, react_valid, react_time, false_start
    );
endinterface

// File: rtl/f1_start_ctrl.sv
// F1 race-start controller: lights 8 lamps one per tick, holds for a pseudo-random
// number of ticks, blanks the bar and measures the player's reaction time.
module f1_start_ctrl #(
    parameter int unsigned TICK_DIV  = 16,
    parameter int unsigned MIN_DELAY = 2
) (
    input  logic           clk,
    input  logic           rst,
    f1_start_ctrl_if.slave bus
);
    localparam int unsigned    TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, GO, DONE} state_t;

    state_t        state, state_d;
    logic [TW-1:0] tick_cnt, tick_cnt_d;
    logic [3:0]    lamp, lamp_d;
    logic [15:0]   dly, dly_d;
    logic [15:0]   rcnt, rcnt_d;
    logic [15:0]   react_time_q, react_time_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    lfsr;
    logic          valid_q, valid_d;
    logic          fs_q, fs_d;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // A react seen in LIGHTS/HOLD aborts even when the same edge carries a tick.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:   if (bus.trigger) state_d = LIGHTS;
            LIGHTS: if (bus.react) state_d = IDLE;
                    else if (tick && lamp == 4'd7) state_d = HOLD;
            HOLD:   if (bus.react) state_d = IDLE;
                    else if (tick && dly == 16'd1) state_d = GO;
            GO:     if (bus.react) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d   = '0;
        lamp_d       = lamp;
        dly_d        = dly;
        rcnt_d       = rcnt;
        react_time_d = react_time_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        fs_d         = 1'b0;
        unique case (state)
            IDLE: begin
                data_d = '0;
                if (bus.trigger) lamp_d = '0;
            end
            LIGHTS: begin
                tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
                if (bus.react) begin
                    fs_d   = 1'b1;
                    data_d = '0;
                end else if (tick) begin
                    lamp_d = lamp + 4'd1;
                    data_d = 8'((9'd1 << (lamp + 4'd1)) - 9'd1);
                    if (lamp == 4'd7) dly_d = 16'(MIN_DELAY) + {12'd0, lfsr[3:0]};
                end
            end
            HOLD: begin
                tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
                if (bus.react) begin
                    fs_d   = 1'b1;
                    data_d = '0;
                end else if (tick) begin
                    if (dly == 16'd1) begin
                        data_d = '0;
                        rcnt_d = '0;
                    end else begin
                        dly_d = dly - 16'd1;
                    end
                end
            end
            GO: begin
                data_d = '0;
                if (bus.react) begin
                    react_time_d = rcnt;
                    valid_d      = 1'b1;
                end else if (rcnt != '1) begin
                    rcnt_d = rcnt + 16'd1;
                end
            end
            DONE: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt     <= '0;
            lamp         <= '0;
            dly          <= '0;
            rcnt         <= '0;
            react_time_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            fs_q         <= 1'b0;
            lfsr         <= 8'h01;
        end else begin
            tick_cnt     <= tick_cnt_d;
            lamp         <= lamp_d;
            dly          <= dly_d;
            rcnt         <= rcnt_d;
            react_time_q <= react_time_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            fs_q         <= fs_d;
            lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign bus.data_out    = data_q;
    assign bus.busy        = (state != IDLE);
    assign bus.react_valid = valid_q;
    assign bus.react_time  = react_time_q;
    assign bus.false_start = fs_q;
endmodule

// File: tb/tb_f1_start_ctrl.sv
// Self-checking bench for f1_start_ctrl: timing of the lamp sequence, hold delay,
// reaction capture, false starts, saturation and asynchronous reset.
module tb_f1_start_ctrl;
    localparam int unsigned TD = 4;
    localparam int unsigned MD = 2;

    logic        clk;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int unsigned ecount;
    logic [15:0] last_rt;

    f1_start_ctrl_if bus ();

    f1_start_ctrl #(.TICK_DIV(TD), .MIN_DELAY(MD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen since reset release; the LFSR has advanced this many times.
    always @(posedge clk or negedge rst) begin
        if (!rst) ecount <= 0;
        else      ecount <= ecount + 1;
    end

    function automatic logic [7:0] lfsr_after(input int unsigned n);
        logic [7:0] v;
        v = 8'h01;
        for (int unsigned i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    function automatic int unsigned hold_ticks(input int unsigned e_trig);
        logic [7:0] v;
        v = lfsr_after(e_trig + 8 * TD - 1);
        return MD + int'(v[3:0]);
    endfunction

    task automatic test_reset();
        rst = 1'b0; bus.trigger = 1'b0; bus.react = 1'b0;
        #12;
        checks++;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.react_valid !== 1'b0 ||
            bus.false_start !== 1'b0 || bus.react_time !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs data=%h busy=%b rv=%b fs=%b rt=%h expected all zero",
                     bus.data_out, bus.busy, bus.react_valid, bus.false_start, bus.react_time);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.react_valid !== 1'b0 ||
                bus.false_start !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d data=%h busy=%b rv=%b fs=%b expected 00/0/0/0",
                         i, bus.data_out, bus.busy, bus.react_valid, bus.false_start);
            end
            checks++;
            if (dut.lfsr !== lfsr_after(ecount)) begin
                errors++;
                $display("FAIL lfsr cyc=%0d got %h expected %h", i, dut.lfsr, lfsr_after(ecount));
            end
        end
        last_rt = 16'h0000;
    endtask

    task automatic run_full(input int unsigned r, input bit both_in_idle, input bit trig_in_go);
        int unsigned eT, d, total, lamps, exp_rt;
        logic [7:0]  exp;
        bus.trigger = 1'b1; bus.react = both_in_idle;
        @(negedge clk);
        bus.trigger = 1'b0; bus.react = 1'b0;
        eT = ecount;
        d = hold_ticks(eT);
        total = 8 * TD + TD * d;
        for (int unsigned c = 0; c <= total; c++) begin
            if (c != 0) @(negedge clk);
            lamps = c / TD;
            if (lamps > 8) lamps = 8;
            exp = (c >= total) ? 8'h00 : 8'((1 << lamps) - 1);
            checks++;
            if (bus.data_out !== exp || bus.busy !== 1'b1 || bus.false_start !== 1'b0 ||
                bus.react_valid !== 1'b0) begin
                errors++;
                $display("FAIL sequence c=%0d D=%0d data=%h busy=%b fs=%b rv=%b expected %h/1/0/0",
                         c, d, bus.data_out, bus.busy, bus.false_start, bus.react_valid, exp);
            end
        end
        for (int unsigned k = 1; k < r; k++) begin
            if (trig_in_go) bus.trigger = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.data_out !== 8'h00 || bus.busy !== 1'b1 || bus.react_valid !== 1'b0) begin
                errors++;
                $display("FAIL go_wait k=%0d data=%h busy=%b rv=%b expected 00/1/0",
                         k, bus.data_out, bus.busy, bus.react_valid);
            end
        end
        bus.trigger = 1'b0; bus.react = 1'b1;
        @(negedge clk);
        exp_rt = (r - 1 > 65535) ? 65535 : r - 1;
        checks++;
        if (bus.react_valid !== 1'b1 || bus.react_time !== 16'(exp_rt) || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL react_capture r=%0d rv=%b rt=%0d busy=%b expected 1/%0d/1",
                     r, bus.react_valid, bus.react_time, bus.busy, exp_rt);
        end
        last_rt = 16'(exp_rt);
        bus.react = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.react_valid !== 1'b0 || bus.busy !== 1'b0 || bus.react_time !== last_rt) begin
            errors++;
            $display("FAIL after_done rv=%b busy=%b rt=%0d expected 0/0/%0d",
                     bus.react_valid, bus.busy, bus.react_time, last_rt);
        end
    endtask

    task automatic test_false_start(input int unsigned sel);
        int unsigned eT, d, total, c;
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        eT = ecount;
        d = hold_ticks(eT);
        total = 8 * TD + TD * d;
        case (sel)
            0:       c = 3 * TD;
            1:       c = TD - 1;
            2:       c = $urandom_range(total - 2, 8 * TD);
            default: c = total - 1;
        endcase
        repeat (c) @(negedge clk);
        if (sel == 0) begin
            checks++;
            if (bus.data_out !== 8'h07) begin
                errors++;
                $display("FAIL fs_pre data=%h expected 07", bus.data_out);
            end
        end
        bus.react = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.false_start !== 1'b1 || bus.data_out !== 8'h00 || bus.busy !== 1'b0 ||
            bus.react_valid !== 1'b0 || bus.react_time !== last_rt) begin
            errors++;
            $display("FAIL false_start sel=%0d c=%0d fs=%b data=%h busy=%b rv=%b rt=%h expected 1/00/0/0/%h",
                     sel, c, bus.false_start, bus.data_out, bus.busy, bus.react_valid,
                     bus.react_time, last_rt);
        end
        bus.react = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.false_start !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL fs_pulse_end fs=%b busy=%b data=%h expected 0/0/00",
                     bus.false_start, bus.busy, bus.data_out);
        end
    endtask

    task automatic test_mid_reset();
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        repeat (8 * TD + 1) @(negedge clk);
        checks++;
        if (bus.data_out !== 8'hFF || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_before_reset data=%h busy=%b expected FF/1", bus.data_out, bus.busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.react_time !== 16'h0000 ||
            bus.react_valid !== 1'b0 || bus.false_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset data=%h busy=%b rt=%h rv=%b fs=%b expected all zero",
                     bus.data_out, bus.busy, bus.react_time, bus.react_valid, bus.false_start);
        end
        last_rt = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_full(5, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        run_full(10, 1'b0, 1'b0);
        run_full(1, 1'b0, 1'b0);
        test_false_start(0);
        test_false_start(1);
        test_false_start(2);
        test_false_start(3);
        for (int i = 0; i < 4; i++) run_full($urandom_range(30, 2), 1'($urandom_range(1, 0)), 1'b0);
        run_full(6, 1'b1, 1'b1);
        test_mid_reset();
        run_full(70001, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
